// File: rtl/mfp_irq_ctrl_pkg.sv
// Shared types and helpers for the MFP 68901 interrupt scheduler.
package mfp_irq_pkg;

  localparam int         MFP_CH       = 16;
  localparam logic [7:0] MFP_SPUR_VEC = 8'h18;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    HOLD = 2'd2
  } irq_state_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] idx;
  } hi_bit_t;

  // Highest set bit of a 16-bit vector; valid is low when the vector is zero.
  function automatic hi_bit_t hi_bit16(input logic [15:0] v);
    hi_bit_t r;
    r.valid = 1'b0;
    r.idx   = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (v[i]) begin
        r.valid = 1'b1;
        r.idx   = i[3:0];
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mfp_prio_enc16.sv
// Combinational 16-to-4 highest-bit priority encoder (bit 15 wins).
module mfp_prio_enc16
  import mfp_irq_pkg::*;
(
  input  logic [15:0] in_vec,
  output logic [3:0]  idx,
  output logic        valid
);

  hi_bit_t enc_s;

  assign enc_s = hi_bit16(in_vec);
  assign idx   = enc_s.idx;
  assign valid = enc_s.valid;

endmodule

// File: rtl/mfp_irq_ctrl.sv
// MFP 68901 interrupt scheduler: masking, priority, in-service gating,
// CPU request and the interrupt-acknowledge sequence.
// Optional feature macro: MFP_ISR_EN (in-service register and S-mode).
// Without it the block runs as automatic end-of-interrupt and isr reads 0.
module mfp_irq_ctrl
  import mfp_irq_pkg::*;
#(
  parameter int         CH       = MFP_CH,
  parameter logic [7:0] SPUR_VEC = MFP_SPUR_VEC
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [CH-1:0] ipr,
  input  logic [CH-1:0] imr,
  input  logic [7:0]    vr,
  input  logic          iack,
  input  logic          isr_wr,
  input  logic [CH-1:0] isr_wdata,
  output logic          irq,
  output logic [7:0]    vector,
  output logic          vector_valid,
  output logic          spurious,
  output logic [CH-1:0] ipr_clr,
  output logic [CH-1:0] isr
);

  irq_state_t    state_r;
  logic          iack_q_r;
  logic [3:0]    ch_q_r;
  logic [CH-1:0] elig_s;
  logic [CH-1:0] one_s;
  logic [3:0]    h_idx_s;
  logic          h_valid_s;
  logic [3:0]    s_idx_s;
  logic          s_valid_s;
  logic          iack_rise_s;
  logic          ack_go_s;
  logic          irq_next_s;
  logic          unused_s;

  assign elig_s      = ipr & imr;
  assign one_s       = {{(CH-1){1'b0}}, 1'b1};
  assign iack_rise_s = iack & ~iack_q_r;
  // Only a request that is still backed by an eligible channel starts an ACK.
  assign ack_go_s    = (state_r == IDLE) & iack_rise_s & irq & h_valid_s;

  mfp_prio_enc16 u_enc_elig (
    .in_vec (elig_s),
    .idx    (h_idx_s),
    .valid  (h_valid_s)
  );

  mfp_prio_enc16 u_enc_isr (
    .in_vec (isr),
    .idx    (s_idx_s),
    .valid  (s_valid_s)
  );

  // Next request: only evaluated while idle and not entering an acknowledge.
  always_comb begin
    irq_next_s = 1'b0;
    if ((state_r == IDLE) && !ack_go_s) begin
`ifdef MFP_ISR_EN
      irq_next_s = h_valid_s && (!s_valid_s || (h_idx_s > s_idx_s));
`else
      irq_next_s = h_valid_s;
`endif
    end else begin
      irq_next_s = 1'b0;
    end
  end

  // Acknowledge state machine with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      iack_q_r     <= 1'b0;
      ch_q_r       <= 4'd0;
      irq          <= 1'b0;
      vector       <= 8'h00;
      vector_valid <= 1'b0;
      spurious     <= 1'b0;
      ipr_clr      <= '0;
    end else begin
      iack_q_r <= iack;
      irq      <= irq_next_s;
      spurious <= 1'b0;
      ipr_clr  <= '0;
      case (state_r)
        IDLE: begin
          if (ack_go_s) begin
            state_r      <= ACK;
            ch_q_r       <= h_idx_s;
            vector       <= {vr[7:4], h_idx_s};
            vector_valid <= 1'b1;
            ipr_clr      <= one_s << h_idx_s;
          end else if (iack_rise_s) begin
            spurious     <= 1'b1;
            vector       <= SPUR_VEC;
            vector_valid <= 1'b1;
          end else begin
            vector_valid <= 1'b0;
          end
        end
        ACK: begin
          // Always passes through HOLD, even if iack already dropped.
          state_r      <= HOLD;
          vector_valid <= 1'b1;
        end
        HOLD: begin
          if (iack) begin
            vector_valid <= 1'b1;
          end else begin
            vector_valid <= 1'b0;
            state_r      <= IDLE;
          end
        end
        default: begin
          state_r      <= IDLE;
          vector_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef MFP_ISR_EN
  logic [CH-1:0] isr_r;
  logic [CH-1:0] isr_next_s;

  // In-service update: S clear wipes it, CPU write clears zeros, ACK set wins.
  always_comb begin
    isr_next_s = isr_r;
    if (!vr[3]) begin
      isr_next_s = '0;
    end else begin
      if (isr_wr) begin
        isr_next_s = isr_r & isr_wdata;
      end else begin
        isr_next_s = isr_r;
      end
      if (state_r == ACK) begin
        isr_next_s = isr_next_s | (one_s << ch_q_r);
      end else begin
        isr_next_s = isr_next_s;
      end
    end
  end

  // In-service register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      isr_r <= '0;
    end else begin
      isr_r <= isr_next_s;
    end
  end

  assign isr      = isr_r;
  assign unused_s = ^{vr[2:0]};
`else
  assign isr      = '0;
  assign unused_s = ^{vr[3:0], isr_wr, isr_wdata, ch_q_r, s_idx_s, s_valid_s};
`endif

endmodule
